// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back
// steps, waits on the memory-ready handshake, and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        PCWriteCond_o,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        MemtoReg_o,
  output logic        RegDst_o,
  output logic        RegWrite_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [2:0]  ALUOp_o,
  output logic [1:0]  PCSource_o,
  output logic [3:0]  state_o,
  output logic        retire_o,
  output logic        illegal_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Held as a plain 4-bit vector so the unused codes 12-15 remain representable.
  logic [3:0]  r_state;
  logic [31:0] r_cnt;
  state_t      w_next;

  logic        w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite, w_irWrite;
  logic        w_memtoReg, w_regDst, w_regWrite, w_aluSrcA, w_retire, w_illegal;
  logic [1:0]  w_aluSrcB, w_pcSource;
  logic [2:0]  w_aluOp;
  logic [2:0]  w_immAluOp;

  assign w_immAluOp = (instr_op_i == OP_SLTI) ? 3'b011 : 3'b000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_memtoReg    = 1'b0;
    w_regDst      = 1'b0;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = 2'b00;
    w_aluOp       = 3'b000;
    w_pcSource    = 2'b00;
    w_retire      = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = 2'b01;
        w_irWrite = mem_ready_i;
        w_pcWrite = mem_ready_i;
        w_next    = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_aluSrcB = 2'b11;
        case (instr_op_i)
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_RTYPE:         w_next = S_R_EXEC;
          OP_BEQ:           w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_ADDI, OP_SLTI: w_next = S_I_EXEC;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
        w_next    = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
        w_next    = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        w_memtoReg = 1'b1;
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEM_WR: begin
        w_memWrite = 1'b1;
        w_iorD     = 1'b1;
        w_retire   = mem_ready_i;
        w_next     = mem_ready_i ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = 3'b010;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        w_regDst   = 1'b1;
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA     = 1'b1;
        w_aluOp       = 3'b001;
        w_pcWriteCond = 1'b1;
        w_pcSource    = 2'b01;
        w_retire      = 1'b1;
      end
      S_JUMP: begin
        w_pcWrite  = 1'b1;
        w_pcSource = 2'b10;
        w_retire   = 1'b1;
      end
      S_I_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
        w_aluOp   = w_immAluOp;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        w_regWrite = 1'b1;
        w_aluOp    = w_immAluOp;
        w_retire   = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Architectural side effects are suppressed for as long as reset is held.
  assign PCWrite_o     = w_pcWrite     & ~rst_i;
  assign PCWriteCond_o = w_pcWriteCond & ~rst_i;
  assign IRWrite_o     = w_irWrite     & ~rst_i;
  assign RegWrite_o    = w_regWrite    & ~rst_i;
  assign MemWrite_o    = w_memWrite    & ~rst_i;
  assign retire_o      = w_retire      & ~rst_i;
  assign illegal_o     = w_illegal     & ~rst_i;
  assign IorD_o        = w_iorD;
  assign MemRead_o     = w_memRead;
  assign MemtoReg_o    = w_memtoReg;
  assign RegDst_o      = w_regDst;
  assign ALUSrcA_o     = w_aluSrcA;
  assign ALUSrcB_o     = w_aluSrcB;
  assign ALUOp_o       = w_aluOp;
  assign PCSource_o    = w_pcSource;
  assign state_o       = r_state;
  assign instr_cnt_o   = r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_cnt <= 32'd0;
    else if (retire_o) r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle outputs are queued as
// stimulus is driven, then popped and compared against the sampled DUT outputs.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [5:0]  instr_op_i = 6'h00;
  logic        mem_ready_i = 1'b0;
  logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic        MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, retire_o, illegal_o;
  logic [1:0]  ALUSrcB_o, PCSource_o;
  logic [2:0]  ALUOp_o;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt_o;

  typedef struct packed {
    logic [22:0] outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] expCnt = 32'd0;
  int          passCnt = 0;
  int          totalCnt = 0;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
    .PCSource_o(PCSource_o), .state_o(state_o), .retire_o(retire_o),
    .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [22:0] obs();
    return {state_o, PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
            MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSource_o,
            retire_o, illegal_o};
  endfunction

  // Reference table of the per-state control word, written from the state list.
  function automatic logic [22:0] expOut(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    logic pcw, pcwc, iord, memr, memw, irw, m2r, rdst, regw, srca, ret, ill;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluop;
    {pcw, pcwc, iord, memr, memw, irw, m2r, rdst, regw, srca, ret, ill} = '0;
    srcb = 2'b00; pcsrc = 2'b00; aluop = 3'b000;
    case (st)
      4'd0:  begin memr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  begin srcb = 2'b11; ill = !(op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0A, 6'h23, 6'h2B}); end
      4'd2:  begin srca = 1; srcb = 2'b10; end
      4'd3:  begin memr = 1; iord = 1; end
      4'd4:  begin m2r = 1; regw = 1; ret = 1; end
      4'd5:  begin memw = 1; iord = 1; ret = rdy; end
      4'd6:  begin srca = 1; aluop = 3'b010; end
      4'd7:  begin rdst = 1; regw = 1; ret = 1; end
      4'd8:  begin srca = 1; aluop = 3'b001; pcwc = 1; pcsrc = 2'b01; ret = 1; end
      4'd9:  begin pcw = 1; pcsrc = 2'b10; ret = 1; end
      4'd10: begin srca = 1; srcb = 2'b10; aluop = (op == 6'h0A) ? 3'b011 : 3'b000; end
      4'd11: begin regw = 1; aluop = (op == 6'h0A) ? 3'b011 : 3'b000; ret = 1; end
      default: ;
    endcase
    return {st, pcw, pcwc, iord, memr, memw, irw, m2r, rdst, regw, srca, srcb, aluop, pcsrc, ret, ill};
  endfunction

  // Drives one cycle at the falling edge, queues its expectation, and leaves time to sample.
  task automatic applyStimulus(input logic [5:0] op, input logic rdy, input logic [3:0] st);
    exp_t e;
    @(negedge clk_i);
    instr_op_i  = op;
    mem_ready_i = rdy;
    e.outs = expOut(st, op, rdy);
    e.cnt  = expCnt;
    sb.push_back(e);
    if (e.outs[1]) expCnt = expCnt + 32'd1;
    #1;
  endtask

  task automatic test_reset();
    logic [22:0] want;
    #1 rst_i = 1'b1;
    #1;
    want = expOut(4'd0, 6'h00, 1'b0);
    totalCnt++;
    if (obs() !== want || instr_cnt_o !== 32'd0)
      $display("[TB] FAIL reset_async: got %h cnt %h, want %h cnt 0", obs(), instr_cnt_o, want);
    else passCnt++;
    mem_ready_i = 1'b1;
    #1;
    totalCnt++;
    if (obs() !== want)
      $display("[TB] FAIL reset_gated: got %h, want %h", obs(), want);
    else passCnt++;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    expCnt = 32'd0;
  endtask

  task automatic test_stream();
    logic [5:0]  ops[7]  = '{6'h00, 6'h08, 6'h0A, 6'h04, 6'h02, 6'h2B, 6'h23};
    logic [19:0] seqs[7] = '{20'h0167, 20'h01AB, 20'h01AB, 20'h018, 20'h019, 20'h0125, 20'h01234};
    int          lens[7] = '{4, 4, 4, 3, 3, 4, 5};
    exp_t        e;
    logic [3:0]  st;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < lens[i]; k++) begin
        st = seqs[i][4*(lens[i]-1-k) +: 4];
        applyStimulus(ops[i], (st == 4'd0 || st == 4'd3 || st == 4'd5) ? 1'b1 : 1'($urandom_range(0, 1)), st);
        e = sb.pop_front();
        totalCnt++;
        if (obs() !== e.outs || instr_cnt_o !== e.cnt)
          $display("[TB] FAIL stream op%h cyc%0d: got %h cnt %h, want %h cnt %h",
                   ops[i], k, obs(), instr_cnt_o, e.outs, e.cnt);
        else passCnt++;
      end
    end
    @(negedge clk_i); #1;
    totalCnt++;
    if (instr_cnt_o !== 32'd7 || state_o !== 4'd0)
      $display("[TB] FAIL stream_count: got cnt %0d state %0d, want cnt 7 state 0", instr_cnt_o, state_o);
    else passCnt++;
    mem_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] sts[7] = '{0, 1, 6, 0, 1, 6, 7};
    exp_t e;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(6'h00, (sts[k] == 4'd0) ? 1'b1 : 1'($urandom_range(0, 1)), sts[k]);
      e = sb.pop_front();
      totalCnt++;
      if (obs() !== e.outs || instr_cnt_o !== e.cnt)
        $display("[TB] FAIL reset_mid cyc%0d: got %h cnt %h, want %h cnt %h", k, obs(), instr_cnt_o, e.outs, e.cnt);
      else passCnt++;
      if (k == 2) begin
        // Abort R_EXEC between clock edges.
        rst_i = 1'b1;
        #1;
        totalCnt++;
        if (state_o !== 4'd0 || instr_cnt_o !== 32'd0)
          $display("[TB] FAIL reset_mid_state: got state %0d cnt %0d, want 0 0", state_o, instr_cnt_o);
        else passCnt++;
        totalCnt++;
        if ({PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, retire_o} !== 6'b0)
          $display("[TB] FAIL reset_mid_strobes: got %b, want 000000",
                   {PCWrite_o, PCWriteCond_o, IRWrite_o, RegWrite_o, MemWrite_o, retire_o});
        else passCnt++;
        expCnt = 32'd0;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
      end
    end
  endtask

  task automatic test_wait_states();
    logic [5:0] ops[16]  = '{6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23,
                             6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B, 6'h2B};
    logic [3:0] sts[16]  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0, 1, 2, 5, 5, 5};
    logic       rdys[16] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1};
    int         irwHigh = 0, regwHigh = 0, retHigh = 0;
    exp_t       e;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(ops[k], rdys[k], sts[k]);
      e = sb.pop_front();
      totalCnt++;
      if (obs() !== e.outs || instr_cnt_o !== e.cnt)
        $display("[TB] FAIL wait cyc%0d: got %h cnt %h, want %h cnt %h", k, obs(), instr_cnt_o, e.outs, e.cnt);
      else passCnt++;
      if (k < 10) begin
        irwHigh  += int'(IRWrite_o);
        regwHigh += int'(RegWrite_o);
      end else begin
        retHigh  += int'(retire_o);
      end
    end
    totalCnt++;
    if (irwHigh != 1 || regwHigh != 1)
      $display("[TB] FAIL wait_lw_pulses: got IRWrite %0d RegWrite %0d, want 1 1", irwHigh, regwHigh);
    else passCnt++;
    totalCnt++;
    if (retHigh != 1)
      $display("[TB] FAIL wait_sw_retire: got %0d retire cycles, want 1", retHigh);
    else passCnt++;
  endtask

  task automatic test_illegal();
    logic [3:0]  sts[3]  = '{0, 1, 0};
    logic        rdys[3] = '{1, 1, 0};
    logic [31:0] cntBefore;
    int          illHigh = 0, retHigh = 0;
    exp_t        e;
    cntBefore = expCnt;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h3F, rdys[k], sts[k]);
      e = sb.pop_front();
      totalCnt++;
      if (obs() !== e.outs || instr_cnt_o !== e.cnt)
        $display("[TB] FAIL illegal cyc%0d: got %h cnt %h, want %h cnt %h", k, obs(), instr_cnt_o, e.outs, e.cnt);
      else passCnt++;
      illHigh += int'(illegal_o);
      retHigh += int'(retire_o);
    end
    totalCnt++;
    if (illHigh != 1 || retHigh != 0 || instr_cnt_o !== cntBefore)
      $display("[TB] FAIL illegal_summary: got illegal %0d retire %0d cnt %h, want 1 0 %h",
               illHigh, retHigh, instr_cnt_o, cntBefore);
    else passCnt++;
  endtask

  task automatic test_wrap();
    logic [3:0] sts[3] = '{0, 1, 8};
    exp_t e;
    @(negedge clk_i);
    force dut.r_cnt = 32'hFFFF_FFFF;
    expCnt = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h04, (k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), sts[k]);
      e = sb.pop_front();
      totalCnt++;
      if (obs() !== e.outs || instr_cnt_o !== e.cnt)
        $display("[TB] FAIL wrap cyc%0d: got %h cnt %h, want %h cnt %h", k, obs(), instr_cnt_o, e.outs, e.cnt);
      else passCnt++;
      if (k == 1) release dut.r_cnt;
    end
    @(negedge clk_i); #1;
    totalCnt++;
    if (instr_cnt_o !== 32'd0)
      $display("[TB] FAIL wrap_count: got %h, want 00000000", instr_cnt_o);
    else passCnt++;
    mem_ready_i = 1'b0;
  endtask

  task automatic test_bad_state();
    logic [22:0] want;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    force dut.r_state = 4'd13;
    #1;
    want = expOut(4'd13, instr_op_i, 1'b0);
    totalCnt++;
    if (obs() !== want)
      $display("[TB] FAIL bad_state_outs: got %h, want %h", obs(), want);
    else passCnt++;
    release dut.r_state;
    @(negedge clk_i); #1;
    want = expOut(4'd0, instr_op_i, 1'b0);
    totalCnt++;
    if (obs() !== want)
      $display("[TB] FAIL bad_state_recover: got %h, want %h", obs(), want);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reset_mid();
    test_wait_states();
    test_illegal();
    test_wrap();
    test_bad_state();
    $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
